// File: rtl/drum_acc.sv
// Saturating dot-product accumulator for DRUM multiplier products.
// Emits a registered result after LEN beats or on an early in_last.
module drum_acc #(
   parameter int unsigned PW    = 32,
   parameter int unsigned ACC_W = 40,
   parameter int unsigned LEN   = 16,
   parameter int unsigned CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PW-1:0]    in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic {ACC, HOLD} state_t;

   state_t             state, state_d;
   logic [ACC_W-1:0]   acc, acc_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               ovf, ovf_d;
   logic               out_valid_d;
   logic [ACC_W-1:0]   out_sum_d;
   logic [CNT_W-1:0]   out_count_d;
   logic               out_ovf_d;

   logic               in_fire;
   logic               out_fire;
   logic [SUM_W-1:0]   nxt;
   logic               sat_now;
   logic [ACC_W-1:0]   sum_sat;
   logic               close;

   // Ready while accumulating, or when the held result drains this cycle.
   assign in_ready = (state == ACC) | out_ready;

   // acc/cnt/ovf are already cleared on entry to HOLD, so the same datapath
   // serves both continuing a vector and starting one during a handoff.
   always_comb begin
      in_fire     = in_valid & in_ready;
      out_fire    = out_valid & out_ready;
      nxt         = {1'b0, acc} + SUM_W'(in_prod);
      sat_now     = nxt[ACC_W];
      sum_sat     = sat_now ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];
      close       = (cnt == CNT_W'(LEN - 1)) | in_last;

      state_d     = state;
      acc_d       = acc;
      cnt_d       = cnt;
      ovf_d       = ovf;
      out_valid_d = out_valid;
      out_sum_d   = out_sum;
      out_count_d = out_count;
      out_ovf_d   = out_ovf;

      if (clr) begin
         state_d     = ACC;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (out_fire) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
         end
         if (in_fire) begin
            if (close) begin
               out_sum_d   = sum_sat;
               out_count_d = cnt + CNT_W'(1);
               out_ovf_d   = ovf | sat_now;
               out_valid_d = 1'b1;
               state_d     = HOLD;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
            end else begin
               acc_d = sum_sat;
               cnt_d = cnt + CNT_W'(1);
               ovf_d = ovf | sat_now;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         cnt       <= cnt_d;
         ovf       <= ovf_d;
         out_valid <= out_valid_d;
         out_sum   <= out_sum_d;
         out_count <= out_count_d;
         out_ovf   <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_drum_acc.sv
// Directed table-driven bench for drum_acc with ACC_W=33, LEN=4.
module tb_drum_acc;

   localparam int unsigned PW    = 32;
   localparam int unsigned ACC_W = 33;
   localparam int unsigned LEN   = 4;
   localparam int unsigned CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic             clr;
      logic             v;
      logic [PW-1:0]    prod;
      logic             last;
      logic             ordy;
      logic             e_ir;
      logic             e_ov;
      logic [ACC_W-1:0] e_sum;
      logic [CNT_W-1:0] e_cnt;
      logic             e_ovf;
   } row_t;

   row_t rows[$];

   drum_acc #(.PW(PW), .ACC_W(ACC_W), .LEN(LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
      end
   endtask

   function automatic void add(input logic c, input logic v, input logic [PW-1:0] p,
                               input logic l, input logic r, input logic ir, input logic ov,
                               input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] n, input logic o);
      row_t t;
      t.clr = c; t.v = v; t.prod = p; t.last = l; t.ordy = r;
      t.e_ir = ir; t.e_ov = ov; t.e_sum = s; t.e_cnt = n; t.e_ovf = o;
      rows.push_back(t);
   endfunction

   // Drive a row mid-cycle, check in_ready before the edge, outputs after it.
   task automatic apply(input int i);
      @(negedge clk);
      clr       = rows[i].clr;
      in_valid  = rows[i].v;
      in_prod   = rows[i].prod;
      in_last   = rows[i].last;
      out_ready = rows[i].ordy;
      #1;
      chk("in_ready", i, 64'(in_ready), 64'(rows[i].e_ir));
      @(posedge clk);
      #1;
      chk("out_valid", i, 64'(out_valid), 64'(rows[i].e_ov));
      chk("out_sum",   i, 64'(out_sum),   64'(rows[i].e_sum));
      chk("out_count", i, 64'(out_count), 64'(rows[i].e_cnt));
      chk("out_ovf",   i, 64'(out_ovf),   64'(rows[i].e_ovf));
   endtask

   localparam logic [ACC_W-1:0] SAT  = {ACC_W{1'b1}};
   localparam logic [PW-1:0]    PMAX = {PW{1'b1}};

   int split;

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

      //   clr v  prod  last rdy | ir ov  sum   cnt ovf
      // basic 4-beat vector including a zero product
      add(0, 1, 15,   0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 100,  0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 0,    0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 7,    0, 1,   1, 1, 122,  4, 0);
      // early close on in_last, then a fresh vector that excludes it
      add(0, 1, 3,    0, 1,   1, 0, 122,  4, 0);
      add(0, 1, 5,    1, 1,   1, 1, 8,    2, 0);
      add(0, 1, 15,   0, 1,   1, 0, 8,    2, 0);
      add(0, 1, 100,  0, 1,   1, 0, 8,    2, 0);
      add(0, 1, 0,    0, 1,   1, 0, 8,    2, 0);
      add(0, 1, 7,    0, 1,   1, 1, 122,  4, 0);
      // backpressure: result held, input pulses ignored
      add(0, 1, 55,   0, 0,   0, 1, 122,  4, 0);
      add(0, 0, 55,   0, 0,   0, 1, 122,  4, 0);
      add(0, 1, 55,   0, 0,   0, 1, 122,  4, 0);
      add(0, 0, 55,   0, 0,   0, 1, 122,  4, 0);
      add(0, 1, 55,   0, 0,   0, 1, 122,  4, 0);
      // handoff and first beat of next vector in the same cycle
      add(0, 1, 9,    0, 1,   1, 0, 122,  4, 0);
      add(0, 1, 1,    0, 1,   1, 0, 122,  4, 0);
      add(0, 1, 1,    0, 1,   1, 0, 122,  4, 0);
      add(0, 1, 1,    0, 1,   1, 1, 12,   4, 0);
      // back-to-back single-beat results
      add(0, 1, 5,    1, 1,   1, 1, 5,    1, 0);
      add(0, 1, 6,    1, 1,   1, 1, 6,    1, 0);
      add(0, 0, 0,    0, 1,   1, 0, 6,    1, 0);
      // saturation, then a clean vector clears ovf
      add(0, 1, PMAX, 0, 1,   1, 0, 6,    1, 0);
      add(0, 1, PMAX, 0, 1,   1, 0, 6,    1, 0);
      add(0, 1, PMAX, 0, 1,   1, 0, 6,    1, 0);
      add(0, 1, PMAX, 0, 1,   1, 1, SAT,  4, 1);
      add(0, 1, 1,    0, 1,   1, 0, SAT,  4, 1);
      add(0, 1, 1,    0, 1,   1, 0, SAT,  4, 1);
      add(0, 1, 1,    0, 1,   1, 0, SAT,  4, 1);
      add(0, 1, 1,    0, 1,   1, 1, 4,    4, 0);
      // clr mid-vector drops the partial sum and the concurrent beat
      add(0, 1, 10,   0, 1,   1, 0, 4,    4, 0);
      add(0, 1, 20,   0, 1,   1, 0, 4,    4, 0);
      add(1, 1, 30,   0, 1,   1, 0, 4,    4, 0);
      add(0, 1, 1,    0, 1,   1, 0, 4,    4, 0);
      add(0, 1, 1,    0, 1,   1, 0, 4,    4, 0);
      add(0, 1, 1,    0, 1,   1, 0, 4,    4, 0);
      add(0, 1, 1,    0, 1,   1, 1, 4,    4, 0);
      // clr in HOLD drops out_valid
      add(1, 0, 0,    0, 0,   0, 0, 4,    4, 0);
      add(0, 1, 2,    1, 0,   1, 1, 2,    1, 0);
      add(0, 1, 50,   0, 0,   0, 1, 2,    1, 0);
      split = rows.size();
      // after an asynchronous reset only post-reset beats count
      add(0, 1, 3,    0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 3,    0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 3,    0, 1,   1, 0, 0,    0, 0);
      add(0, 1, 3,    0, 1,   1, 1, 12,   4, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", -1, 64'(out_valid), 64'(0));
      chk("rst_out_sum",   -1, 64'(out_sum),   64'(0));
      chk("rst_out_count", -1, 64'(out_count), 64'(0));
      chk("rst_out_ovf",   -1, 64'(out_ovf),   64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < split; i++) apply(i);

      // async reset between edges while a result is held
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_last = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", -2, 64'(out_valid), 64'(0));
      chk("async_out_sum",   -2, 64'(out_sum),   64'(0));
      chk("async_out_count", -2, 64'(out_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = split; i < rows.size(); i++) apply(i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
